// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- hazard and control unit for a 5-stage pipeline.
//   Resolves EX operand forwarding, load-use bubbles, taken-branch and
//   overflow redirects, and the stall window of a multi-cycle MULT/DIV unit.
// Ports:
//   clk, rst                         clock, async active-high reset
//   rs_D, rt_D                       ID source registers
//   rs_E, rt_E                       EX source registers
//   reg_src3_E/M/W, RegWrite_E/M/W   destination register + write enable per stage
//   MemToReg_E                       EX instruction is a load
//   BranchM, ZeroM, OverflowM        MEM-stage branch/overflow status
//   MdStart_E                        MULT/DIV issue from EX
//   StallF, StallD                   hold PC and IF/ID
//   FlushD, FlushE, FlushM           zero IF/ID, ID/EX, EX/MEM control
//   ForwardA_E, ForwardB_E           00 regfile, 10 MEM alu_out, 01 WB result
//   PcSel                            00 PC+4, 01 branch target, 10 exception vector
//   md_busy                          MULT/DIV unit occupied

// Per-operand forwarding select. MEM has priority over WB; r0 never forwards.
module pipe_fwd #(
   parameter int RA = 4
) (
   input  logic [RA:0] src,
   input  logic [RA:0] dst_m,
   input  logic        wr_m,
   input  logic [RA:0] dst_w,
   input  logic        wr_w,
   output logic [1:0]  fwd
);
   always_comb begin
      fwd = 2'b00;
      if (wr_m && (dst_m != '0) && (dst_m == src))
         fwd = 2'b10;
      else if (wr_w && (dst_w != '0) && (dst_w == src))
         fwd = 2'b01;
   end
endmodule

module pipe_ctrl #(
   parameter int RA     = 4,
   parameter int MD_LAT = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [RA:0] rs_D,
   input  logic [RA:0] rt_D,
   input  logic [RA:0] rs_E,
   input  logic [RA:0] rt_E,
   input  logic [RA:0] reg_src3_E,
   input  logic [RA:0] reg_src3_M,
   input  logic [RA:0] reg_src3_W,
   input  logic        RegWrite_E,
   input  logic        RegWrite_M,
   input  logic        RegWrite_W,
   input  logic        MemToReg_E,
   input  logic        BranchM,
   input  logic        ZeroM,
   input  logic        OverflowM,
   input  logic        MdStart_E,
   output logic        StallF,
   output logic        StallD,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushM,
   output logic [1:0]  ForwardA_E,
   output logic [1:0]  ForwardB_E,
   output logic [1:0]  PcSel,
   output logic        md_busy
);

   typedef enum logic [1:0] {RUN, MD_WAIT, EXC} state_t;

   state_t     state, state_nxt;
   logic [5:0] md_cnt, md_cnt_nxt;

   // ---------------- forwarding: operand 0 = rs_E, operand 1 = rt_E
   logic [1:0][RA:0] src_e;
   logic [1:0][1:0]  fwd_sel;

   assign src_e = {rt_E, rs_E};

   for (genvar g = 0; g < 2; g++) begin : g_fwd
      pipe_fwd #(.RA(RA)) u_fwd (
         .src   (src_e[g]),
         .dst_m (reg_src3_M),
         .wr_m  (RegWrite_M),
         .dst_w (reg_src3_W),
         .wr_w  (RegWrite_W),
         .fwd   (fwd_sel[g])
      );
   end

   assign ForwardA_E = fwd_sel[0];
   assign ForwardB_E = fwd_sel[1];

   // ---------------- hazard terms
   logic lu, br_taken, ovf;

   assign lu       = MemToReg_E && RegWrite_E && (reg_src3_E != '0) &&
                     ((reg_src3_E == rs_D) || (reg_src3_E == rt_D));
   assign br_taken = BranchM && ZeroM;
   // Overflow redirects from RUN and MD_WAIT; in EXC it is the trap already
   // being taken, so a second one is dropped.
   assign ovf      = OverflowM && (state != EXC);

   assign md_busy  = (state == MD_WAIT);

   // ---------------- state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   // ---------------- next state
   always_comb begin
      state_nxt  = state;
      md_cnt_nxt = md_cnt;
      case (state)
         RUN: begin
            // overflow wins over a coincident MULT/DIV issue, which is dropped
            if (OverflowM) begin
               state_nxt = EXC;
            end else if (MdStart_E) begin
               state_nxt  = MD_WAIT;
               md_cnt_nxt = 6'(MD_LAT - 1);
            end
         end
         MD_WAIT: begin
            // branches/overflows here do not disturb the countdown
            md_cnt_nxt = md_cnt - 6'd1;
            if (md_cnt == 6'd1)
               state_nxt = RUN;
         end
         EXC:     state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // ---------------- control outputs, priority ovf > branch > md stall > lu
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushM = 1'b0;
      PcSel  = 2'b00;
      if (!rst) begin
         if (ovf) begin
            PcSel  = 2'b10;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
         end else if (br_taken) begin
            PcSel  = 2'b01;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
         end else if (state == EXC) begin
            // squash the instruction fetched behind the trap; fetch proceeds
            FlushD = 1'b1;
         end else if ((state == MD_WAIT) && MdStart_E) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end else if (lu) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs_D, rt_D, rs_E, rt_E, reg_src3_E, reg_src3_M, reg_src3_W;
   logic       RegWrite_E, RegWrite_M, RegWrite_W, MemToReg_E;
   logic       BranchM, ZeroM, OverflowM, MdStart_E;
   logic       StallF, StallD, FlushD, FlushE, FlushM, md_busy;
   logic [1:0] ForwardA_E, ForwardB_E, PcSel;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(.RA(4), .MD_LAT(32)) dut (
      .clk(clk), .rst(rst),
      .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
      .reg_src3_E(reg_src3_E), .reg_src3_M(reg_src3_M), .reg_src3_W(reg_src3_W),
      .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
      .MemToReg_E(MemToReg_E), .BranchM(BranchM), .ZeroM(ZeroM),
      .OverflowM(OverflowM), .MdStart_E(MdStart_E),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .FlushM(FlushM), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
      .PcSel(PcSel), .md_busy(md_busy)
   );

   task automatic clear_inputs();
      rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0;
      reg_src3_E = 0; reg_src3_M = 0; reg_src3_W = 0;
      RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0; MemToReg_E = 0;
      BranchM = 0; ZeroM = 0; OverflowM = 0; MdStart_E = 0;
   endtask

   // control outputs packed as {StallF,StallD,FlushD,FlushE,FlushM,PcSel}
   function automatic logic [6:0] ctl();
      return {StallF, StallD, FlushD, FlushE, FlushM, PcSel};
   endfunction

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      BranchM = 1; ZeroM = 1;
      rs_E = 5'd3; reg_src3_M = 5'd3; RegWrite_M = 1;
      @(negedge clk); #1;
      tests++;
      if (ctl() !== 7'b0000000) begin
         fails++; $display("FAIL reset_ctl got %b exp %b", ctl(), 7'b0000000);
      end
      tests++;
      if (md_busy !== 1'b0) begin
         fails++; $display("FAIL reset_busy got %b exp 0", md_busy);
      end
      tests++;
      if (ForwardA_E !== 2'b10) begin
         fails++; $display("FAIL reset_fwd got %b exp 10", ForwardA_E);
      end
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;
      #1;
      tests++;
      if (ctl() !== 7'b0000000) begin
         fails++; $display("FAIL post_reset_ctl got %b exp 0000000", ctl());
      end
   endtask

   task automatic test_forward();
      @(negedge clk);
      clear_inputs();
      rs_E = 5'd5; reg_src3_M = 5'd5; RegWrite_M = 1; reg_src3_W = 5'd5; RegWrite_W = 1;
      #1;
      tests++;
      if (ForwardA_E !== 2'b10) begin
         fails++; $display("FAIL fwd_mem got %b exp 10", ForwardA_E);
      end
      RegWrite_M = 0; #1;
      tests++;
      if (ForwardA_E !== 2'b01) begin
         fails++; $display("FAIL fwd_wb got %b exp 01", ForwardA_E);
      end
      rs_E = 5'd0; reg_src3_M = 0; reg_src3_W = 0; RegWrite_M = 1; #1;
      tests++;
      if (ForwardA_E !== 2'b00) begin
         fails++; $display("FAIL fwd_r0 got %b exp 00", ForwardA_E);
      end
      // independent operands: A from WB r7, B from MEM r9
      rs_E = 5'd7; rt_E = 5'd9; reg_src3_M = 5'd9; RegWrite_M = 1;
      reg_src3_W = 5'd7; RegWrite_W = 1; #1;
      tests++;
      if ({ForwardA_E, ForwardB_E} !== 4'b0110) begin
         fails++; $display("FAIL fwd_pair got %b exp 0110", {ForwardA_E, ForwardB_E});
      end
      clear_inputs();
   endtask

   task automatic test_load_use();
      @(negedge clk);
      clear_inputs();
      MemToReg_E = 1; RegWrite_E = 1; reg_src3_E = 5'd8; rt_D = 5'd8; rs_D = 5'd2;
      #1;
      tests++;
      if (ctl() !== 7'b1101000) begin
         fails++; $display("FAIL lu_stall got %b exp 1101000", ctl());
      end
      // next cycle: the load is in MEM, dependent instruction in EX
      @(negedge clk);
      clear_inputs();
      reg_src3_M = 5'd8; RegWrite_M = 1; rt_E = 5'd8; rs_E = 5'd2;
      #1;
      tests++;
      if ({ctl(), ForwardB_E} !== 9'b0000000_10) begin
         fails++; $display("FAIL lu_after got %b exp 000000010", {ctl(), ForwardB_E});
      end
      // load into r0 never creates a hazard
      @(negedge clk);
      clear_inputs();
      MemToReg_E = 1; RegWrite_E = 1; reg_src3_E = 5'd0; rs_D = 5'd0;
      #1;
      tests++;
      if (ctl() !== 7'b0000000) begin
         fails++; $display("FAIL lu_r0 got %b exp 0000000", ctl());
      end
      clear_inputs();
   endtask

   task automatic test_branch();
      @(negedge clk);
      clear_inputs();
      MemToReg_E = 1; RegWrite_E = 1; reg_src3_E = 5'd8; rt_D = 5'd8;
      BranchM = 1; ZeroM = 1;
      #1;
      tests++;
      if (ctl() !== 7'b0011101) begin
         fails++; $display("FAIL br_lu got %b exp 0011101", ctl());
      end
      ZeroM = 0; #1;
      tests++;
      if (ctl() !== 7'b1101000) begin
         fails++; $display("FAIL br_not_taken got %b exp 1101000", ctl());
      end
      clear_inputs();
   endtask

   task automatic test_overflow();
      @(negedge clk);
      clear_inputs();
      OverflowM = 1; BranchM = 1; ZeroM = 1;
      #1;
      tests++;
      if (ctl() !== 7'b0011110) begin
         fails++; $display("FAIL ovf_cycle got %b exp 0011110", ctl());
      end
      // EXC: second overflow ignored, load-use must not stall fetch
      @(negedge clk);
      clear_inputs();
      OverflowM = 1;
      MemToReg_E = 1; RegWrite_E = 1; reg_src3_E = 5'd4; rs_D = 5'd4;
      #1;
      tests++;
      if (ctl() !== 7'b0010000) begin
         fails++; $display("FAIL exc_cycle got %b exp 0010000", ctl());
      end
      @(negedge clk);
      clear_inputs();
      #1;
      tests++;
      if (ctl() !== 7'b0000000) begin
         fails++; $display("FAIL exc_return got %b exp 0000000", ctl());
      end
      // overflow coinciding with MdStart_E drops the MULT/DIV start
      OverflowM = 1; MdStart_E = 1;
      @(negedge clk);
      clear_inputs();
      #1;
      tests++;
      if ({md_busy, FlushD} !== 2'b01) begin
         fails++; $display("FAIL ovf_md got %b exp 01", {md_busy, FlushD});
      end
      @(negedge clk);
      #1;
      tests++;
      if (md_busy !== 1'b0) begin
         fails++; $display("FAIL ovf_md_after got %b exp 0", md_busy);
      end
   endtask

   task automatic test_md_wait();
      int busy_cnt = 0;
      @(negedge clk);
      clear_inputs();
      MdStart_E = 1;
      #1;
      tests++;
      if ({md_busy, StallF} !== 2'b00) begin
         fails++; $display("FAIL md_issue got %b exp 00", {md_busy, StallF});
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         MdStart_E = (i == 9);
         BranchM = (i == 4); ZeroM = (i == 4);
         #1;
         if (md_busy) busy_cnt++;
         if (i == 9) begin
            tests++;
            if (ctl() !== 7'b1101000) begin
               fails++; $display("FAIL md_stall got %b exp 1101000", ctl());
            end
         end
         if (i == 20) begin
            tests++;
            if (ctl() !== 7'b0000000) begin
               fails++; $display("FAIL md_nostall got %b exp 0000000", ctl());
            end
         end
      end
      tests++;
      if (busy_cnt != 31) begin
         fails++; $display("FAIL md_busy_len got %0d exp 31", busy_cnt);
      end
      clear_inputs();
   endtask

   task automatic test_md_reset();
      @(negedge clk);
      clear_inputs();
      MdStart_E = 1;
      @(negedge clk);
      MdStart_E = 0;
      repeat (4) @(negedge clk);
      MdStart_E = 1;
      #1;
      tests++;
      if ({md_busy, StallF} !== 2'b11) begin
         fails++; $display("FAIL mdr_before got %b exp 11", {md_busy, StallF});
      end
      #1 rst = 1'b1;
      #1;
      tests++;
      if ({md_busy, StallF, StallD, FlushE} !== 4'b0000) begin
         fails++; $display("FAIL mdr_async got %b exp 0000", {md_busy, StallF, StallD, FlushE});
      end
      @(negedge clk);
      rst = 1'b0;
      MdStart_E = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         tests++;
         if ({md_busy, ctl()} !== 8'b0) begin
            fails++; $display("FAIL mdr_release%0d got %b exp 00000000", i, {md_busy, ctl()});
         end
      end
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      test_reset();
      test_forward();
      test_load_use();
      test_branch();
      test_overflow();
      test_md_wait();
      test_md_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameters: RA=4, register-address MSB (5-bit addresses); MD_LAT=32, multi-cycle MULT/DIV latency in cycles (legal range 2..63).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 rs_D, rt_D  in  RA+1  source registers of the instruction in ID.
REQ-005 rs_E, rt_E  in  RA+1  source registers of the instruction in EX.
REQ-006 reg_src3_E, reg_src3_M, reg_src3_W  in  RA+1  destination registers in EX/MEM/WB.
REQ-007 RegWrite_E, RegWrite_M, RegWrite_W  in  1  destination write enable per stage.
REQ-008 MemToReg_E  in  1  instruction in EX is a load.
REQ-009 BranchM, ZeroM  in  1  branch in MEM; taken when both are 1.
REQ-010 OverflowM  in  1  arithmetic overflow for the instruction in MEM.
REQ-011 MdStart_E  in  1  MULT/DIV issues from EX in this cycle.
REQ-012 StallF, StallD  out  1  hold the PC and the IF/ID register.
REQ-013 FlushD, FlushE, FlushM  out  1  zero the IF/ID, ID/EX, and EX/MEM control fields.
REQ-014 ForwardA_E, ForwardB_E  out  2  EX operand select: 00 = register file, 10 = MEM alu_out, 01 = WB result.
REQ-015 PcSel  out  2  00 = PC+4, 01 = branch target, 10 = exception vector.
REQ-016 md_busy  out  1  MULT/DIV unit occupied.

Function
REQ-017 FSM states: RUN, MD_WAIT, EXC; 6-bit down-counter md_cnt.
REQ-018 Forwarding, per operand independently: select 10 if RegWrite_M and reg_src3_M is nonzero and equals the source; else 01 if RegWrite_W and reg_src3_W is nonzero and equals the source; else 00. MEM wins when MEM and WB both match. Register 0 never forwards.
REQ-019 Load-use: lu = MemToReg_E and RegWrite_E and reg_src3_E nonzero and (reg_src3_E == rs_D or reg_src3_E == rt_D).
REQ-020 lu drives StallF=1, StallD=1, FlushE=1 for exactly the cycle(s) in which it holds; this produces a 1-cycle bubble.
REQ-021 A taken branch (BranchM and ZeroM) drives PcSel=01 and FlushD=FlushE=FlushM=1 in the same cycle, combinationally.
REQ-022 In RUN, OverflowM drives PcSel=10 and FlushD=FlushE=FlushM=1 in the same cycle, and the FSM moves to EXC.
REQ-023 EXC lasts exactly 1 cycle; FlushD=1 and StallF=0 in that cycle; the FSM then returns to RUN. A second overflow in EXC is ignored.
REQ-024 In RUN, MdStart_E moves the FSM to MD_WAIT and loads md_cnt=MD_LAT-1.
REQ-025 In MD_WAIT, md_busy=1 and md_cnt decrements each cycle; the FSM returns to RUN on the edge where md_cnt==1, so md_busy is high for MD_LAT-1 cycles after the issue cycle.
REQ-026 MdStart_E is ignored outside RUN.
REQ-027 In MD_WAIT, StallF=StallD=1 and FlushE=1 when the ID instruction would also issue (MdStart_E).
REQ-028 Priority when events coincide: overflow > taken branch > MD_WAIT stall > load-use.
REQ-029 A higher-priority flush overrides stalls: StallF=StallD=0 whenever PcSel≠00.
REQ-030 A taken branch or overflow during MD_WAIT does not abort the counter.
REQ-031 Overflow in the same cycle as MdStart_E: the FSM goes to EXC and the MULT/DIV start is dropped.
REQ-032 All outputs except md_busy and the FSM effects are combinational from the current inputs and state, with zero-cycle latency.

Reset
REQ-033 While rst=1, the FSM is in RUN, md_cnt=0, md_busy=0, StallF=StallD=0, FlushD=FlushE=FlushM=0, PcSel=00; forwarding still follows REQ-018.
REQ-034 rst asserted mid-MD_WAIT or in EXC returns the FSM to RUN immediately (asynchronously), with no residual stall after release.

Verification
REQ-035 rs_E=5, reg_src3_M=5, RegWrite_M=1, reg_src3_W=5, RegWrite_W=1 -> ForwardA_E=10; then RegWrite_M=0 -> ForwardA_E=01; then rs_E=0 with all matches -> ForwardA_E=00.
REQ-036 Load into r8 in EX, rt_D=8 -> one cycle of StallF=StallD=FlushE=1; next cycle, forwarding selects 10 for r8.
REQ-037 BranchM=ZeroM=1 in the same cycle as lu -> PcSel=01, FlushD/E/M=1, StallF=0.
REQ-038 MdStart_E pulse with MD_LAT=32 -> md_busy high for 31 cycles; a MdStart_E in cycle 10 of that window has no effect on the count.
REQ-039 OverflowM=1 -> PcSel=10 with all flushes in that cycle, then 1 cycle of EXC with FlushD=1, then RUN.
REQ-040 rst pulse in cycle 5 of MD_WAIT -> md_busy=0 immediately; after release, no stall while MdStart_E=0.
